// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the three-master bus arbiter
package bus_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int NUM_MASTERS            = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Read data returned to a master whose transaction timed out
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot pick over three requesters
module rr_arbiter
    import bus_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             last,
    output logic [NUM_MASTERS-1:0] grant
);

    // Search order starts just after the most recent owner and wraps back to it
    always_comb begin
        grant = '0;
        case (last)
            2'd0: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd1: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter for CPU data, CPU fetch and DMA onto one slave port
// Optional slave-ack timeout: define BUS_ARB_TIMEOUT_EN
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [1:0]  m0_sel_i,
    input  logic        m0_rd_i,
    input  logic        m0_we_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [1:0]  m1_sel_i,
    input  logic        m1_rd_i,
    input  logic        m1_we_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    input  logic [31:0] m2_addr_i,
    input  logic [31:0] m2_data_i,
    input  logic [1:0]  m2_sel_i,
    input  logic        m2_rd_i,
    input  logic        m2_we_i,
    output logic [31:0] m2_data_o,
    output logic        m2_ack_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [1:0]  s_sel_o,
    output logic        s_rd_o,
    output logic        s_we_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic [2:0]  grant_o,
    output logic        err_o
);

    state_t                 state;
    logic [1:0]             last;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick;
    logic [1:0]             gidx;
    logic                   busy;
    logic                   live;
    logic                   req_g;
    logic                   tmo;
    logic                   done;
    logic [31:0]            rdata;

    assign req   = {m2_rd_i | m2_we_i, m1_rd_i | m1_we_i, m0_rd_i | m0_we_i};
    assign busy  = (state == ST_BUSY);
    // A transaction cut by reset must never complete, so reset masks completion
    assign live  = busy & ~rst;
    assign req_g = |(req & grant_o);
    assign gidx  = grant_o[2] ? 2'd2 : (grant_o[1] ? 2'd1 : 2'd0);

    rr_arbiter u_rr (
        .req   (req),
        .last  (last),
        .grant (pick)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;

    // A real slave ack always beats the timeout; an aborted request never times out
    assign tmo   = live & req_g & ~s_ack_i & (tmo_cnt == TMO_LAST);
    assign err_o = tmo;

    // Counts BUSY cycles without ack; held at zero while IDLE so each grant starts fresh
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else if (!done) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo   = 1'b0;
    // Timeout disabled: constant 0 (TIMEOUT_CYCLES is never negative)
    assign err_o = (TIMEOUT_CYCLES < 0);
`endif

    assign done  = live & (s_ack_i | tmo);
    assign rdata = tmo ? TIMEOUT_RDATA : s_data_i;

    assign m0_ack_o  = done & grant_o[0];
    assign m1_ack_o  = done & grant_o[1];
    assign m2_ack_o  = done & grant_o[2];
    assign m0_data_o = (busy & grant_o[0]) ? rdata : 32'h0;
    assign m1_data_o = (busy & grant_o[1]) ? rdata : 32'h0;
    assign m2_data_o = (busy & grant_o[2]) ? rdata : 32'h0;

    // Shared slave port follows the current owner; quiet when nobody owns the bus
    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        s_rd_o   = 1'b0;
        s_we_o   = 1'b0;
        if (busy && grant_o[0]) begin
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
            s_sel_o  = m0_sel_i;
            s_rd_o   = m0_rd_i;
            s_we_o   = m0_we_i;
        end else if (busy && grant_o[1]) begin
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
            s_sel_o  = m1_sel_i;
            s_rd_o   = m1_rd_i;
            s_we_o   = m1_we_i;
        end else if (busy && grant_o[2]) begin
            s_addr_o = m2_addr_i;
            s_data_o = m2_data_i;
            s_sel_o  = m2_sel_i;
            s_rd_o   = m2_rd_i;
            s_we_o   = m2_we_i;
        end
    end

    // IDLE/BUSY control: one arbitration cycle, then hold the owner until ack, timeout or abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            last    <= 2'd2;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state   <= ST_BUSY;
                        grant_o <= pick;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        state   <= ST_IDLE;
                        grant_o <= '0;
                        last    <= gidx;
                    end else if (!req_g) begin
                        state   <= ST_IDLE;
                        grant_o <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

endmodule
